// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the datapath
// registers it steers.
package ctrl_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Per-stage pipeline register control: hold the current contents or load a NOP.
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard sources from the datapath and the per-stage hold/bubble enables sent back to it.
interface pipeline_ctrl_if;

    logic [4:0] raddr1D;
    logic [4:0] raddr2D;
    logic       rs1_usedD;
    logic       rs2_usedD;
    logic [4:0] waddrE;
    logic       reg_wrE;
    logic       loadE;
    logic       br_takenE;
    logic       dmem_reqM;
    logic       dmem_ack;

    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushW;

    modport master (
        output raddr1D, raddr2D, rs1_usedD, rs2_usedD, waddrE, reg_wrE, loadE,
               br_takenE, dmem_reqM, dmem_ack,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );

    modport slave (
        input  raddr1D, raddr2D, rs1_usedD, rs2_usedD, waddrE, reg_wrE, loadE,
               br_takenE, dmem_reqM, dmem_ack,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, taken-branch
// and memory-wait hazards, plus a memory-wait watchdog and performance counters.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no data-memory access outstanding, watchdog cleared
//   ST_WAIT | M-stage access pending without ack, watchdog counting
module pipeline_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   pif,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic        mem_busy;
    logic        lw_hazard;
    logic        rs1_hit;
    logic        rs2_hit;

    logic        stall_f;
    logic        stall_m;
    logic        flush_w;
    stage_ctrl_t ctrl_d;
    stage_ctrl_t ctrl_e;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_d;
    logic            err_set;

    assign mem_busy  = pif.dmem_reqM & ~pif.dmem_ack;
    assign rs1_hit   = pif.rs1_usedD & (pif.raddr1D == pif.waddrE);
    assign rs2_hit   = pif.rs2_usedD & (pif.raddr2D == pif.waddrE);
    assign lw_hazard = pif.loadE & pif.reg_wrE & (pif.waddrE != REG_ZERO) & (rs1_hit | rs2_hit);

    // A pending memory access freezes F..M, so E's branch/load is re-judged on release.
    always_comb begin
        stall_f = 1'b0;
        stall_m = 1'b0;
        flush_w = 1'b0;
        ctrl_d  = '0;
        ctrl_e  = '0;
        if (mem_busy) begin
            stall_f      = 1'b1;
            ctrl_d.stall = 1'b1;
            ctrl_e.stall = 1'b1;
            stall_m      = 1'b1;
            flush_w      = 1'b1;
        end else if (pif.br_takenE) begin
            ctrl_d.flush = 1'b1;
            ctrl_e.flush = 1'b1;
        end else if (lw_hazard) begin
            stall_f      = 1'b1;
            ctrl_d.stall = 1'b1;
            ctrl_e.flush = 1'b1;
        end
    end

    assign pif.stallF = stall_f;
    assign pif.stallD = ctrl_d.stall;
    assign pif.stallE = ctrl_e.stall;
    assign pif.stallM = stall_m;
    assign pif.flushD = ctrl_d.flush;
    assign pif.flushE = ctrl_e.flush;
    assign pif.flushW = flush_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_busy) state_d = ST_WAIT;
            ST_WAIT: if (pif.dmem_ack || !pif.dmem_reqM) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Cleared on the way out of WAIT so a back-to-back access starts from zero.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == ST_WAIT) && mem_busy) begin
            wait_cnt_d = (wait_cnt == WC_MAX) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    assign err_set = mem_busy && (wait_cnt == WC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            mem_err  <= mem_err | err_set;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_f),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_d.flush | ctrl_e.flush),
        .count (flush_cnt)
    );

endmodule
